// File: rtl/box_fill_engine_pkg.sv
// Shared constants, state encoding and clip helper for the box fill engine.
// The screen geometry and colour constants are the ones the display
// sequencer also uses, so both sides agree on cell size and screen limits.
package box_fill_engine_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int CELL_W  = 64;
    localparam int CELL_H  = 24;
    localparam int BOX_W   = CELL_W;
    localparam int BOX_H   = CELL_H;
    localparam int COLOR_W = 9;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int DX_W    = $clog2(BOX_W);
    localparam int DY_W    = $clog2(BOX_H);

    localparam logic [COLOR_W-1:0] COLOR_BLACK   = 9'h000;
    localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 9'h1C7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Full-width visibility test: coordinates carry one extra bit so a box
    // running past the right/bottom edge never wraps back onto the screen.
    function automatic logic on_screen(input logic [X_W:0] px,
                                       input logic [Y_W:0] py);
        return (px < 11'(H_RES)) && (py < 10'(V_RES));
    endfunction

endpackage

// File: rtl/box_scan_counter.sv
// Row-major dx/dy scan counter for one box. clr restarts at (0,0), en steps
// one pixel. The next-state values are exported so the engine can register
// its pixel outputs in the same cycle the counter moves.
module box_scan_counter #(
    parameter int W    = 64,
    parameter int H    = 24,
    parameter int DX_W = $clog2(W),
    parameter int DY_W = $clog2(H)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_i,
    output logic [DX_W-1:0] dx_nxt_o,
    output logic [DY_W-1:0] dy_nxt_o,
    output logic            last_o
);

    logic [DX_W-1:0] dx_q;
    logic [DX_W-1:0] dx_d;
    logic [DY_W-1:0] dy_q;
    logic [DY_W-1:0] dy_d;

    // Next position: clear wins, otherwise step with wrap at the row end.
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clr_i) begin
            dx_d = {DX_W{1'b0}};
            dy_d = {DY_W{1'b0}};
        end else if (en_i) begin
            if (dx_q == DX_W'(W - 1)) begin
                dx_d = {DX_W{1'b0}};
                dy_d = dy_q + DY_W'(1);
            end else begin
                dx_d = dx_q + DX_W'(1);
            end
        end else begin
            dx_d = dx_q;
            dy_d = dy_q;
        end
    end

    // Position register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dx_q <= {DX_W{1'b0}};
            dy_q <= {DY_W{1'b0}};
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx_nxt_o = dx_d;
    assign dy_nxt_o = dy_d;
    assign last_o   = (dx_q == DX_W'(W - 1)) && (dy_q == DY_W'(H - 1));

endmodule

// File: rtl/box_fill_engine.sv
// Box fill engine: accepts a {x0, y0, color} command from the sequencer,
// walks the box in row-major order issuing one framebuffer write per
// accepted beat (off-screen pixels are skipped in one cycle each) and
// pulses done for a single cycle. All outputs come straight from flops.
module box_fill_engine
    import box_fill_engine_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_we,
    input  logic               pix_ready
);

    state_e               state_q, state_d;
    logic [X_W-1:0]       x0_q, x0_d;
    logic [Y_W-1:0]       y0_q, y0_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pix_we_q, pix_we_d;
    logic [X_W-1:0]       pix_x_q, pix_x_d;
    logic [Y_W-1:0]       pix_y_q, pix_y_d;

    logic                 cnt_clr_s;
    logic                 cnt_en_s;
    logic [DX_W-1:0]      dx_nxt_s;
    logic [DY_W-1:0]      dy_nxt_s;
    logic                 last_s;
    logic                 cmd_off_s;
    logic                 advance_s;
    logic [X_W:0]         px_full_s;
    logic [Y_W:0]         py_full_s;

    box_scan_counter #(
        .W    (BOX_W),
        .H    (BOX_H),
        .DX_W (DX_W),
        .DY_W (DY_W)
    ) u_cnt (
        .clk_i    (CLOCK_50),
        .rst_ni   (resetn),
        .clr_i    (cnt_clr_s),
        .en_i     (cnt_en_s),
        .dx_nxt_o (dx_nxt_s),
        .dy_nxt_o (dy_nxt_s),
        .last_o   (last_s)
    );

    // A box whose origin is already off-screen produces no pixels at all.
    assign cmd_off_s = (x0 >= 10'(H_RES)) || (y0 >= 9'(V_RES));

    // Visible pixels wait for the framebuffer; clipped ones step immediately.
    always_comb begin
        advance_s = 1'b1;
        if (pix_we_q) begin
            advance_s = pix_ready;
        end else begin
            advance_s = 1'b1;
        end
    end

    // Command FSM: accept in IDLE or FIN, scan, then one FIN cycle.
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        color_d   = color_q;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    x0_d      = x0;
                    y0_d      = y0;
                    color_d   = color;
                    cnt_clr_s = 1'b1;
                    state_d   = cmd_off_s ? ST_FIN : ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (advance_s) begin
                    cnt_en_s = 1'b1;
                    state_d  = last_s ? ST_FIN : ST_SCAN;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the next position.
    always_comb begin
        px_full_s = {1'b0, x0_d} + 11'(dx_nxt_s);
        py_full_s = {1'b0, y0_d} + 10'(dy_nxt_s);
        busy_d    = (state_d == ST_SCAN);
        done_d    = (state_d == ST_FIN);
        pix_we_d  = busy_d && on_screen(px_full_s, py_full_s);
        pix_x_d   = px_full_s[X_W-1:0];
        pix_y_d   = py_full_s[Y_W-1:0];
    end

    // State, command latch and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            x0_q     <= {X_W{1'b0}};
            y0_q     <= {Y_W{1'b0}};
            color_q  <= COLOR_BLACK;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pix_we_q <= 1'b0;
            pix_x_q  <= {X_W{1'b0}};
            pix_y_q  <= {Y_W{1'b0}};
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            color_q  <= color_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pix_we_q <= pix_we_d;
            pix_x_q  <= pix_x_d;
            pix_y_q  <= pix_y_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_we    = pix_we_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = color_q;

endmodule

// File: tb/tb_box_fill_engine.sv
// Directed bench for box_fill_engine: reset, basic fill, backpressure,
// clipping and start/done handshake corners.
module tb_box_fill_engine;
    import box_fill_engine_pkg::*;

    logic         CLOCK_50 = 1'b0;
    logic         resetn;
    logic         start;
    logic [9:0]   x0;
    logic [8:0]   y0;
    logic [8:0]   color;
    logic         busy;
    logic         done;
    logic [9:0]   pix_x;
    logic [8:0]   pix_y;
    logic [8:0]   pix_color;
    logic         pix_we;
    logic         pix_ready;

    int checks = 0;
    int errors = 0;

    // Per-run observations gathered by run_box.
    int q_x[$];
    int q_y[$];
    int q_c[$];
    int done_cyc;
    int busy_cnt;
    int hold_viol;
    int overlap_cnt;
    int last_acc;
    int first_we;
    int done_pulses = 0;

    box_fill_engine dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .color     (color),
        .busy      (busy),
        .done      (done),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .pix_we    (pix_we),
        .pix_ready (pix_ready)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Issue one command and record what the DUT does until done (bounded).
    // mode 0: pix_ready always 1; mode 1: pseudo-random pix_ready.
    // inj_iter > 0 re-pulses start with other coordinates mid-scan.
    task automatic run_box(input logic [9:0] bx, input logic [8:0] by,
                           input logic [8:0] bc, input int mode,
                           input int inj_iter);
        int i;
        logic have_hold;
        logic [9:0] hx;
        logic [8:0] hy;
        logic rdy;
        q_x.delete(); q_y.delete(); q_c.delete();
        done_cyc = -1; busy_cnt = 0; hold_viol = 0; overlap_cnt = 0;
        last_acc = -1; first_we = -1; have_hold = 1'b0;
        hx = 10'd0; hy = 9'd0;
        x0 = bx; y0 = by; color = bc; start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        i = 1;
        while (i <= 10000) begin
            if (have_hold) begin
                if (pix_we !== 1'b1 || pix_x !== hx || pix_y !== hy) hold_viol++;
                have_hold = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                if (pix_we === 1'b1) overlap_cnt++;
                done_cyc = i;
                done_pulses++;
                break;
            end
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            pix_ready = rdy;
            if (pix_we === 1'b1) begin
                if (first_we < 0) first_we = i;
                if (rdy) begin
                    q_x.push_back(int'(pix_x));
                    q_y.push_back(int'(pix_y));
                    q_c.push_back(int'(pix_color));
                    last_acc = i;
                end else begin
                    have_hold = 1'b1; hx = pix_x; hy = pix_y;
                end
            end
            if (i == inj_iter) begin
                start = 1'b1; x0 = 10'd300; y0 = 9'd300; color = 9'h000;
            end else if (i == inj_iter + 1) begin
                start = 1'b0;
            end
            @(posedge CLOCK_50); #1;
            i++;
        end
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; pix_ready = 1'b1;
        x0 = 10'd5; y0 = 9'd5; color = 9'h1FF;
        repeat (3) @(posedge CLOCK_50);
        #1;
        checks++;
        if ({busy, done, pix_we, pix_x, pix_y, pix_color} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, pix_we, pix_x, pix_y, pix_color});
        end
        resetn = 1'b1;
        @(posedge CLOCK_50); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic saw_done;
        x0 = 10'd100; y0 = 9'd50; color = COLOR_MAGENTA; pix_ready = 1'b1;
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        #1;
        checks++;
        if (pix_x !== 10'd110 || pix_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan_pos: got x=%0d we=%b expected 110 1", pix_x, pix_we);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pix_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_drop: got busy=%b we=%b expected 0 0", busy, pix_we);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge CLOCK_50); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        resetn = 1'b1;
        repeat (2) begin
            @(posedge CLOCK_50); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done seen=%b expected 0", saw_done);
        end
        run_box(10'd200, 9'd100, 9'h038, 0, -1);
        checks++;
        if (q_x.size() != 1536 || q_x[0] != 200 || q_y[0] != 100) begin
            errors++;
            $display("FAIL restart_origin: got n=%0d first=(%0d,%0d) expected 1536 (200,100)",
                     q_x.size(), (q_x.size() > 0) ? q_x[0] : -1, (q_y.size() > 0) ? q_y[0] : -1);
        end
    endtask

    task automatic test_basic_fill();
        int bad_col;
        run_box(10'd64, 9'd48, 9'h1C7, 0, -1);
        checks++;
        if (q_x.size() != 1536) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 1536", q_x.size());
        end
        checks++;
        if (q_x.size() == 0 || q_x[0] != 64 || q_y[0] != 48) begin
            errors++;
            $display("FAIL basic_first: got (%0d,%0d) expected (64,48)",
                     (q_x.size() > 0) ? q_x[0] : -1, (q_y.size() > 0) ? q_y[0] : -1);
        end
        checks++;
        if (q_x.size() == 0 || q_x[q_x.size()-1] != 127 || q_y[q_y.size()-1] != 71) begin
            errors++;
            $display("FAIL basic_last: got (%0d,%0d) expected (127,71)",
                     (q_x.size() > 0) ? q_x[q_x.size()-1] : -1, (q_y.size() > 0) ? q_y[q_y.size()-1] : -1);
        end
        bad_col = 0;
        foreach (q_c[k]) if (q_c[k] != 'h1C7) bad_col++;
        checks++;
        if (bad_col != 0) begin
            errors++;
            $display("FAIL basic_color: got %0d wrong colours expected 0", bad_col);
        end
        checks++;
        if (done_cyc != 1537 || busy_cnt != 1536) begin
            errors++;
            $display("FAIL basic_timing: got done@%0d busy=%0d expected 1537 1536", done_cyc, busy_cnt);
        end
        checks++;
        if (overlap_cnt != 0 || done_cyc != last_acc + 1) begin
            errors++;
            $display("FAIL basic_done_after_last: got overlap=%0d done@%0d last@%0d expected 0 and last+1",
                     overlap_cnt, done_cyc, last_acc);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        int ex, ey;
        run_box(10'd128, 9'd96, 9'h0AA, 1, -1);
        checks++;
        if (q_x.size() != 1536) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 1536", q_x.size());
        end
        bad = 0;
        for (int k = 0; k < 1536; k++) begin
            ex = 128 + k % 64; ey = 96 + k / 64;
            if (k >= q_x.size()) bad++;
            else if (q_x[k] != ex || q_y[k] != ey || q_c[k] != 'h0AA) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_order: got %0d misplaced writes expected 0", bad);
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable stalls expected 0", hold_viol);
        end
        checks++;
        if (done_cyc != last_acc + 1 || overlap_cnt != 0) begin
            errors++;
            $display("FAIL bp_done: got done@%0d last@%0d overlap=%0d expected last+1 0",
                     done_cyc, last_acc, overlap_cnt);
        end
    endtask

    task automatic test_clipping();
        int j, bad;
        int ex, ey;
        // Bottom-right cell: fits exactly, all 1536 pixels visible.
        run_box(10'd576, 9'd456, 9'h1FF, 0, -1);
        checks++;
        if (q_x.size() != 1536 || q_x[q_x.size()-1] != 639 || q_y[q_y.size()-1] != 479) begin
            errors++;
            $display("FAIL clip_edge_cell: got n=%0d expected 1536 ending (639,479)", q_x.size());
        end
        // Straddles right and bottom edges: 40 x 10 visible pixels.
        run_box(10'd600, 9'd470, 9'h015, 0, -1);
        j = 0; bad = 0;
        for (int k = 0; k < 1536; k++) begin
            ex = 600 + k % 64; ey = 470 + k / 64;
            if (ex < 640 && ey < 480) begin
                if (j >= q_x.size()) bad++;
                else if (q_x[j] != ex || q_y[j] != ey) bad++;
                j++;
            end
        end
        checks++;
        if (q_x.size() != 400 || bad != 0) begin
            errors++;
            $display("FAIL clip_partial: got n=%0d bad=%0d expected 400 0", q_x.size(), bad);
        end
        checks++;
        if (done_cyc != 1537) begin
            errors++;
            $display("FAIL clip_partial_done: got %0d expected 1537", done_cyc);
        end
        // Origin off the right edge: no writes, straight to FIN.
        run_box(10'd640, 9'd10, 9'h111, 0, -1);
        checks++;
        if (q_x.size() != 0 || first_we != -1 || done_cyc != 1 || busy_cnt != 0) begin
            errors++;
            $display("FAIL clip_off_x: got n=%0d done@%0d busy=%0d expected 0 1 0", q_x.size(), done_cyc, busy_cnt);
        end
        // Origin off the bottom edge.
        run_box(10'd10, 9'd480, 9'h111, 0, -1);
        checks++;
        if (q_x.size() != 0 || done_cyc != 1) begin
            errors++;
            $display("FAIL clip_off_y: got n=%0d done@%0d expected 0 1", q_x.size(), done_cyc);
        end
    endtask

    task automatic test_handshake();
        int bad;
        logic extra;
        done_pulses = 0;
        // start pulse mid-scan with different coordinates must be ignored.
        run_box(10'd0, 9'd0, 9'h007, 0, 100);
        bad = 0;
        for (int k = 0; k < 1536; k++) begin
            if (k >= q_x.size()) bad++;
            else if (q_x[k] != k % 64 || q_y[k] != k / 64 || q_c[k] != 'h007) bad++;
        end
        checks++;
        if (q_x.size() != 1536 || bad != 0 || done_cyc != 1537) begin
            errors++;
            $display("FAIL start_in_scan: got n=%0d bad=%0d done@%0d expected 1536 0 1537",
                     q_x.size(), bad, done_cyc);
        end
        // Now sitting in the FIN cycle: kick the next box immediately.
        run_box(10'd320, 9'd240, 9'h1C0, 0, -1);
        checks++;
        if (first_we != 1 || q_x.size() != 1536 || q_x[0] != 320 || q_y[0] != 240) begin
            errors++;
            $display("FAIL start_in_fin: got first@%0d n=%0d expected 1 1536 at (320,240)",
                     first_we, q_x.size());
        end
        checks++;
        if (busy_cnt != 1536 || done_cyc != 1537) begin
            errors++;
            $display("FAIL fin_restart_timing: got busy=%0d done@%0d expected 1536 1537", busy_cnt, done_cyc);
        end
        extra = 1'b0;
        repeat (5) begin
            @(posedge CLOCK_50); #1;
            if (done === 1'b1) extra = 1'b1;
        end
        checks++;
        if (done_pulses != 2 || extra !== 1'b0) begin
            errors++;
            $display("FAIL done_pulses: got %0d (extra=%b) expected 2", done_pulses, extra);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_scan();
        test_basic_fill();
        test_backpressure();
        test_clipping();
        test_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
